usb_crc5_arbiter: RTL and testbench

- Shares one bit-serial USB CRC5 engine (x^5+x^2+1) between two requesters: requester 0 is the TX token builder (generate), requester 1 is the RX token checker (generate and compare).
- Each job covers one 11-bit token field {endp[3:0], addr[6:0]}.
- Arbitration is round-robin. The result returns on a shared response bus tagged with the requester ID.
- Sits between the USB packet encoder/decoder and the CRC logic.

---
 rtl/usb_crc5_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_usb_crc5_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc5_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_crc5_arbiter
//  Description : Round-robin shared bit-serial USB CRC5 (x^5+x^2+1) engine.
//                Requester 0 (TX token builder) gets a generated CRC5.
//                Requester 1 (RX token checker) gets a generated CRC5 plus a
//                compare flag against the CRC5 it received on the wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_crc5_arbiter #(
    parameter int         DATA_W   = 11,
    parameter logic [4:0] CRC_INIT = 5'b11111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [DATA_W-1:0] i_req_data0,
    input  logic [DATA_W-1:0] i_req_data1,
    input  logic [4:0]        i_req_crc1,
    output logic              o_busy,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [4:0]        o_rsp_crc,
    output logic              o_rsp_match
);

    localparam int               CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [4:0]       C_POLY     = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_lfsr;
    logic [DATA_W-1:0]  r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant;
    logic               r_id;
    logic [4:0]         r_crc1;
    logic               r_rsp_id;
    logic [4:0]         r_rsp_crc;
    logic               r_rsp_match;

    logic [1:0]         w_valid;
    logic               w_grant_any;
    logic               w_grant_id;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_fb;
    logic [4:0]         w_lfsr_nxt;
    logic [4:0]         w_crc_final;

    // Round-robin grant: a lone requester always wins; on contention the one
    // that did not win last time is chosen. Requests are masked during reset.
    always_comb begin
        w_valid     = i_req_valid & {2{~rst}};
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        case (w_valid)
            2'b01: begin
                w_grant_any = 1'b1;
                w_grant_id  = 1'b0;
            end
            2'b10: begin
                w_grant_any = 1'b1;
                w_grant_id  = 1'b1;
            end
            2'b11: begin
                w_grant_any = 1'b1;
                w_grant_id  = ~r_last_grant;
            end
            default: begin
                w_grant_any = 1'b0;
                w_grant_id  = 1'b0;
            end
        endcase
    end

    // One LFSR step per SHIFT cycle, LSB of the field first.
    always_comb begin
        w_fb        = r_lfsr[4] ^ r_sr[0];
        w_lfsr_nxt  = {r_lfsr[3:0], 1'b0} ^ (w_fb ? C_POLY : 5'b00000);
        w_crc_final = ~w_lfsr_nxt;
        w_last_bit  = (r_cnt == C_CNT_LAST);
    end

    // Next-state and handshake outputs; ready only exists in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 2'b00;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_any) begin
                    o_req_ready = w_grant_id ? 2'b10 : 2'b01;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job capture on accept and the serial CRC datapath during SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= CRC_INIT;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_id         <= 1'b0;
            r_crc1       <= 5'b00000;
            r_last_grant <= 1'b1;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_sr         <= w_grant_id ? i_req_data1 : i_req_data0;
                    r_id         <= w_grant_id;
                    r_last_grant <= w_grant_id;
                    r_lfsr       <= CRC_INIT;
                    r_cnt        <= '0;
                    // Only the RX checker supplies a received CRC to compare.
                    if (w_grant_id) begin
                        r_crc1 <= i_req_crc1;
                    end
                end
            end else if (r_state == ST_SHIFT) begin
                r_lfsr <= w_lfsr_nxt;
                r_sr   <= r_sr >> 1;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    // Result registers load on the final shift so they are valid throughout
    // DONE and hold until the next job completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id    <= 1'b0;
            r_rsp_crc   <= 5'b00000;
            r_rsp_match <= 1'b0;
        end else if ((r_state == ST_SHIFT) && w_last_bit) begin
            r_rsp_id    <= r_id;
            r_rsp_crc   <= w_crc_final;
            r_rsp_match <= r_id & (w_crc_final == r_crc1);
        end
    end

    // Status and response outputs.
    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_rsp_valid = (r_state == ST_DONE);
        o_rsp_id    = r_rsp_id;
        o_rsp_crc   = r_rsp_crc;
        o_rsp_match = r_rsp_match;
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_crc5_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_crc5_arbiter
//  Description : Self-checking bench for usb_crc5_arbiter with directed and
//                randomized jobs against a behavioural CRC5/arbiter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_crc5_arbiter;

    localparam int DATA_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [4:0]        req_crc1;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_id;
    logic [4:0]        rsp_crc;
    logic              rsp_match;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    usb_crc5_arbiter #(
        .DATA_W   (DATA_W),
        .CRC_INIT (5'b11111)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data0 (req_data0),
        .i_req_data1 (req_data1),
        .i_req_crc1  (req_crc1),
        .o_busy      (busy),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_crc   (rsp_crc),
        .o_rsp_match (rsp_match)
    );

    // USB CRC5 of a token field: preset all ones, x^5+x^2+1, LSB first,
    // result inverted.
    function automatic logic [4:0] crc_ref(input logic [DATA_W-1:0] d);
        logic [4:0] rem;
        rem = 5'b11111;
        for (int i = 0; i < DATA_W; i++) begin
            if (rem[4] != d[i]) rem = {rem[3:0], 1'b0} ^ 5'b00101;
            else                rem = {rem[3:0], 1'b0};
        end
        return ~rem;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, check the grant and follow the job to its
    // response. hold keeps req_valid asserted; poke scrambles inputs mid-job.
    task automatic run_job(input logic [1:0] v, input logic [DATA_W-1:0] d0,
                           input logic [DATA_W-1:0] d1, input logic [4:0] c1,
                           input bit hold, input bit poke);
        int         gid;
        int         n;
        bit         bad;
        logic [4:0] exp_crc;
        logic       exp_match;
        req_valid = v;
        req_data0 = d0;
        req_data1 = d1;
        req_crc1  = c1;
        #1;
        if (v == 2'b11) gid = (model_last == 1) ? 0 : 1;
        else            gid = v[1] ? 1 : 0;
        chk("grant", req_ready, (gid == 1) ? 2'b10 : 2'b01);
        model_last = gid;
        exp_crc   = crc_ref((gid == 1) ? d1 : d0);
        exp_match = (gid == 1) && (exp_crc == c1);
        step();
        if (poke) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = ~d0;
            req_data1 = ~d1;
            req_crc1  = ~c1;
        end else if (!hold) begin
            req_valid = 2'b00;
        end
        n   = 1;
        bad = 0;
        while (!rsp_valid && n < 30) begin
            if (!busy || req_ready != 2'b00) bad = 1;
            step();
            n++;
        end
        chk("latency", n, 12);
        chk("busy_window", bad, 0);
        chk("done_busy", busy, 1);
        chk("done_ready", req_ready, 2'b00);
        chk("rsp_id", rsp_id, gid);
        chk("rsp_crc", rsp_crc, exp_crc);
        chk("rsp_match", rsp_match, exp_match);
        step();
        chk("valid_pulse", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        chk("crc_hold", rsp_crc, exp_crc);
    endtask

    initial begin
        int bad;
        logic [1:0]        v;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [4:0]        c1;

        // Reset with both requests asserted: nothing may be granted.
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data0 = '0;
        req_data1 = '0;
        req_crc1  = '0;
        step();
        step();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_crc", rsp_crc, 5'h00);
        chk("rst_rsp_match", rsp_match, 0);
        req_valid  = 2'b00;
        rst        = 1'b0;
        model_last = 1;
        step();

        // Single TX job; data changed after accept must not matter.
        run_job(2'b01, 11'h715, 11'h000, 5'h00, 1'b0, 1'b1);
        // RX check pass and fail.
        run_job(2'b10, 11'h000, 11'h53A, 5'h1C, 1'b0, 1'b0);
        run_job(2'b10, 11'h000, 11'h53A, 5'h1D, 1'b0, 1'b0);

        // Sustained contention: alternate grants, back-to-back every 13 cycles.
        for (int k = 0; k < 4; k++) begin
            run_job(2'b11, 11'h715, 11'h53A, 5'h1C, 1'b1, 1'b0);
        end
        req_valid = 2'b00;

        // No request: engine stays idle.
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy || rsp_valid) bad = 1;
        end
        chk("idle_quiet", bad, 0);

        // Reset in the middle of a TX job.
        req_valid = 2'b01;
        req_data0 = 11'h715;
        #1;
        chk("pre_abort_grant", req_ready, 2'b01);
        step();
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", req_ready, 2'b00);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_crc", rsp_crc, 5'h00);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_match", rsp_match, 0);
        model_last = 1;
        step();
        rst       = 1'b0;
        req_valid = 2'b00;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (rsp_valid || busy) bad = 1;
        end
        chk("abort_no_rsp", bad, 0);
        run_job(2'b11, 11'h715, 11'h53A, 5'h1C, 1'b0, 1'b0);

        // Randomized jobs.
        for (int k = 0; k < 40; k++) begin
            v  = 2'($urandom_range(1, 3));
            d0 = DATA_W'($urandom);
            d1 = DATA_W'($urandom);
            c1 = ($urandom_range(0, 1) == 1) ? crc_ref(d1) : 5'($urandom);
            run_job(v, d0, d1, c1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
